// File: rtl/signal_demodulator_pkg.sv
// Shared widths, cfg_data field positions and enums for the I/Q demodulator.
package signal_demodulator_pkg;

  localparam int unsigned AXIS_TDATA_WIDTH = 16;
  localparam int unsigned ADC_WIDTH        = 14;
  localparam int unsigned CFG_DATA_WIDTH   = 64;
  localparam int unsigned ACC_WIDTH        = 48;
  localparam int unsigned LEN_WIDTH        = 16;
  localparam int unsigned PROD_WIDTH       = 2 * AXIS_TDATA_WIDTH;
  localparam int unsigned CNT_CMP_WIDTH    = LEN_WIDTH + 1;

  // cfg_data field positions
  localparam int unsigned REF_TYPE_LSB = 0;
  localparam int unsigned REF_TYPE_MSB = 2;
  localparam int unsigned ENABLE_BIT   = 3;
  localparam int unsigned LEN_LSB      = 16;
  localparam int unsigned LEN_MSB      = 31;

  typedef enum logic [REF_TYPE_MSB-REF_TYPE_LSB:0] {
    REF_SINE   = 3'd0,
    REF_SQUARE = 3'd1
  } ref_type_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // A block length of zero behaves as a single-sample block.
  function automatic logic [LEN_WIDTH-1:0] eff_len(input logic [LEN_WIDTH-1:0] n);
    return (n == '0) ? LEN_WIDTH'(1) : n;
  endfunction

endpackage

// File: rtl/signal_demodulator_mac.sv
// One demodulator channel: S2 product (or sign-select) and S3 accumulator.
// Square-reference path is built only when DEMOD_SQUARE_REF_EN is defined.
module demod_mac
  import signal_demodulator_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_flush,
  input  logic                               i_s2_vld,
  input  logic                               i_last,
  input  logic                               i_square,
  input  logic signed [AXIS_TDATA_WIDTH-1:0] i_adc,
  input  logic signed [AXIS_TDATA_WIDTH-1:0] i_ref,
  output logic signed [ACC_WIDTH-1:0]        o_sum_c
);

  logic signed [PROD_WIDTH-1:0] r_prod_mul;
  logic signed [PROD_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]  r_acc;

  // S2: signed 16x16 product of the registered sample and reference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod_mul <= '0;
    end else begin
      r_prod_mul <= PROD_WIDTH'(i_adc) * PROD_WIDTH'(i_ref);
    end
  end

`ifdef DEMOD_SQUARE_REF_EN
  logic signed [PROD_WIDTH-1:0] r_prod_sq;

  // S2: square reference reduces to +adc / -adc by the reference sign
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod_sq <= '0;
    end else begin
      r_prod_sq <= i_ref[AXIS_TDATA_WIDTH-1] ? -PROD_WIDTH'(i_adc) : PROD_WIDTH'(i_adc);
    end
  end

  assign w_prod = i_square ? r_prod_sq : r_prod_mul;
`else
  logic w_square_unused;
  assign w_square_unused = i_square;
  assign w_prod          = r_prod_mul;
`endif

  // Running sum including the product currently in S2
  assign o_sum_c = r_acc + ACC_WIDTH'(w_prod);

  // S3: accumulate; restart on the block's last sample so the next block has no gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_flush) begin
      r_acc <= '0;
    end else if (i_s2_vld) begin
      r_acc <= i_last ? '0 : o_sum_c;
    end
  end

endmodule

// File: rtl/signal_demodulator.sv
// Lock-in style I/Q demodulator: ADC x DDS reference integrated over N samples,
// one {Q, I} result per block on an AXI-Stream master.
// Optional square-reference mode is enabled by defining DEMOD_SQUARE_REF_EN.
module signal_demodulator
  import signal_demodulator_pkg::*;
(
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_adc_tdata,
  input  logic                          s_axis_adc_tvalid,
  input  logic [2*AXIS_TDATA_WIDTH-1:0] s_axis_ref_tdata,
  input  logic                          s_axis_ref_tvalid,
  input  logic [CFG_DATA_WIDTH-1:0]     cfg_data,
  output logic [2*ACC_WIDTH-1:0]        m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          status_overrun
);

  state_e                              r_state;
  logic                                r_s1_vld;
  logic signed [AXIS_TDATA_WIDTH-1:0]  r_s1_adc;
  logic signed [AXIS_TDATA_WIDTH-1:0]  r_s1_cos;
  logic signed [AXIS_TDATA_WIDTH-1:0]  r_s1_sin;
  logic                                r_s2_vld;
  logic [LEN_WIDTH-1:0]                r_cnt;
  logic [LEN_WIDTH-1:0]                r_len;
  logic [2*ACC_WIDTH-1:0]              r_tdata;
  logic                                r_tvalid;
  logic                                r_overrun;

  logic                                w_enable;
  logic                                w_flush;
  logic                                w_accept;
  logic                                w_blk_start;
  logic [LEN_WIDTH-1:0]                w_cfg_len;
  logic [LEN_WIDTH-1:0]                w_len;
  logic                                w_last;
  logic                                w_result;
  logic                                w_square;
  logic signed [ACC_WIDTH-1:0]         w_sum_i;
  logic signed [ACC_WIDTH-1:0]         w_sum_q;
  logic                                w_cfg_unused;

  assign w_enable    = cfg_data[ENABLE_BIT];
  assign w_flush     = !w_enable;
  assign w_accept    = s_axis_adc_tvalid && s_axis_ref_tvalid && w_enable;

  // Block parameters are taken from cfg on the first sample of a block, held otherwise
  assign w_blk_start = (r_cnt == '0);
  assign w_cfg_len   = eff_len(cfg_data[LEN_MSB:LEN_LSB]);
  assign w_len       = w_blk_start ? w_cfg_len : r_len;
  assign w_last      = r_s2_vld &&
                       ((CNT_CMP_WIDTH'(r_cnt) + CNT_CMP_WIDTH'(1)) == CNT_CMP_WIDTH'(w_len));
  assign w_result    = w_last && w_enable;

`ifdef DEMOD_SQUARE_REF_EN
  logic r_square;
  logic w_cfg_square;

  assign w_cfg_square = (ref_type_e'(cfg_data[REF_TYPE_MSB:REF_TYPE_LSB]) == REF_SQUARE);
  assign w_square     = w_blk_start ? w_cfg_square : r_square;
  assign w_cfg_unused = ^{cfg_data[CFG_DATA_WIDTH-1:LEN_MSB+1],
                          cfg_data[LEN_LSB-1:ENABLE_BIT+1]};
`else
  assign w_square     = 1'b0;
  assign w_cfg_unused = ^{cfg_data[CFG_DATA_WIDTH-1:LEN_MSB+1],
                          cfg_data[LEN_LSB-1:ENABLE_BIT+1],
                          cfg_data[REF_TYPE_MSB:REF_TYPE_LSB]};
`endif

  // S1: capture jointly-valid input samples
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_s1_vld <= 1'b0;
      r_s1_adc <= '0;
      r_s1_cos <= '0;
      r_s1_sin <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_adc <= $signed(s_axis_adc_tdata);
        r_s1_cos <= $signed(s_axis_ref_tdata[AXIS_TDATA_WIDTH-1:0]);
        r_s1_sin <= $signed(s_axis_ref_tdata[2*AXIS_TDATA_WIDTH-1:AXIS_TDATA_WIDTH]);
      end
    end
  end

  // S2 valid: dropping enable discards whatever is in flight
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_s2_vld <= 1'b0;
    end else begin
      r_s2_vld <= w_flush ? 1'b0 : r_s1_vld;
    end
  end

  demod_mac u_mac_i (
    .clk      (clk),
    .rst_n    (aresetn),
    .i_flush  (w_flush),
    .i_s2_vld (r_s2_vld),
    .i_last   (w_last),
    .i_square (w_square),
    .i_adc    (r_s1_adc),
    .i_ref    (r_s1_cos),
    .o_sum_c  (w_sum_i)
  );

  demod_mac u_mac_q (
    .clk      (clk),
    .rst_n    (aresetn),
    .i_flush  (w_flush),
    .i_s2_vld (r_s2_vld),
    .i_last   (w_last),
    .i_square (w_square),
    .i_adc    (r_s1_adc),
    .i_ref    (r_s1_sin),
    .o_sum_c  (w_sum_q)
  );

  // Block FSM: state, sample counter and per-block latched configuration
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_len    <= LEN_WIDTH'(1);
`ifdef DEMOD_SQUARE_REF_EN
      r_square <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_enable) begin
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          if (!w_enable) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_s2_vld) begin
            if (w_blk_start) begin
              r_len    <= w_cfg_len;
`ifdef DEMOD_SQUARE_REF_EN
              r_square <= w_cfg_square;
`endif
            end
            r_cnt <= w_last ? '0 : r_cnt + LEN_WIDTH'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Output register: a new result always wins; overwriting an unaccepted one is sticky-flagged
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_result) begin
        r_tdata  <= {w_sum_q, w_sum_i};
        r_tvalid <= 1'b1;
        if (r_tvalid && !m_axis_tready) begin
          r_overrun <= 1'b1;
        end
      end else if (r_tvalid && m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
      if (r_state == IDLE) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign m_axis_tdata   = r_tdata;
  assign m_axis_tvalid  = r_tvalid;
  assign status_overrun = r_overrun;

endmodule

// File: tb/tb_signal_demodulator.sv
// Directed bench for signal_demodulator with a result scoreboard.
module tb_signal_demodulator;

  logic        clk;
  logic        aresetn;
  logic [15:0] s_axis_adc_tdata;
  logic        s_axis_adc_tvalid;
  logic [31:0] s_axis_ref_tdata;
  logic        s_axis_ref_tvalid;
  logic [63:0] cfg_data;
  logic [95:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        status_overrun;

  int          n_assert;
  int          n_fail;
  logic [95:0] q_exp[$];

  signal_demodulator dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .s_axis_adc_tdata  (s_axis_adc_tdata),
    .s_axis_adc_tvalid (s_axis_adc_tvalid),
    .s_axis_ref_tdata  (s_axis_ref_tdata),
    .s_axis_ref_tvalid (s_axis_ref_tvalid),
    .cfg_data          (cfg_data),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .status_overrun    (status_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [95:0] pk(input longint i, input longint q);
    logic [63:0] iv;
    logic [63:0] qv;
    iv = i;
    qv = q;
    return {qv[47:0], iv[47:0]};
  endfunction

  function automatic logic [63:0] mk_cfg(input int n, input bit en, input int typ);
    logic [63:0] c;
    c        = '0;
    c[31:16] = 16'(n);
    c[3]     = en;
    c[2:0]   = 3'(typ);
    return c;
  endfunction

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one clock worth of input, return just after the edge
  task automatic step(input int adc, input int c, input int s, input bit av, input bit rv);
    s_axis_adc_tdata  = 16'(adc);
    s_axis_ref_tdata  = {16'(s), 16'(c)};
    s_axis_adc_tvalid = av;
    s_axis_ref_tvalid = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1'b0, 1'b0);
  endtask

  // Scoreboard: every accepted output beat must match the oldest expected result
  always @(negedge clk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      if (q_exp.size() == 0) begin
        check("sb_underflow", 96'(q_exp.size()), 96'd1);
      end else begin
        check("result", m_axis_tdata, q_exp.pop_front());
      end
    end
  end

  initial begin
    n_assert          = 0;
    n_fail            = 0;
    aresetn           = 1'b0;
    s_axis_adc_tdata  = '0;
    s_axis_adc_tvalid = 1'b0;
    s_axis_ref_tdata  = '0;
    s_axis_ref_tvalid = 1'b0;
    cfg_data          = '0;
    m_axis_tready     = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", 96'(m_axis_tvalid), 96'd0);
    check("rst_tdata", m_axis_tdata, 96'd0);
    check("rst_overrun", 96'(status_overrun), 96'd0);
    aresetn = 1'b1;

    // Sine, N=4: results after edges 5 and 9 (t+3), back-to-back blocks
    cfg_data = mk_cfg(4, 1'b1, 0);
    for (int k = 0; k < 11; k++) begin
      if (k == 0 || k == 4) q_exp.push_back(pk(65536000, 0));
      if (k < 8) step(1000, 16384, 0, 1'b1, 1'b1);
      else       idle(1);
      check("sine_tvalid", 96'(m_axis_tvalid), 96'((k == 5) || (k == 9)));
    end
    cfg_data = mk_cfg(4, 1'b0, 0);
    idle(2);

    // Type 1, N=2, cos=-5, sin=7
    cfg_data = mk_cfg(2, 1'b1, 1);
`ifdef DEMOD_SQUARE_REF_EN
    q_exp.push_back(pk(-2000, 2000));
`else
    q_exp.push_back(pk(-10000, 14000));
`endif
    step(1000, -5, 7, 1'b1, 1'b1);
    step(1000, -5, 7, 1'b1, 1'b1);
    idle(4);
    check("sq_tvalid_done", 96'(m_axis_tvalid), 96'd0);
    cfg_data = mk_cfg(2, 1'b0, 0);
    idle(2);

    // ref_tvalid on odd steps only: accepted adc = 101,103,105,107
    cfg_data = mk_cfg(4, 1'b1, 0);
    q_exp.push_back(pk(832, -1248));
    for (int k = 0; k < 8; k++) step(100 + k, 2, -3, 1'b1, (k % 2) == 1);
    for (int j = 0; j < 4; j++) begin
      idle(1);
      check("gap_tvalid", 96'(m_axis_tvalid), 96'(j == 1));
    end
    cfg_data = mk_cfg(4, 1'b0, 0);
    idle(2);

    // Overrun: two blocks with tready low, second replaces first
    m_axis_tready = 1'b0;
    cfg_data = mk_cfg(2, 1'b1, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) q_exp.push_back(pk(14, 14));
      step((k < 2) ? 5 : 7, 1, 1, 1'b1, 1'b1);
    end
    idle(3);
    check("ovr_tvalid", 96'(m_axis_tvalid), 96'd1);
    check("ovr_flag", 96'(status_overrun), 96'd1);
    check("ovr_tdata", m_axis_tdata, pk(14, 14));
    cfg_data = mk_cfg(2, 1'b0, 0);
    idle(2);
    check("ovr_clr_idle", 96'(status_overrun), 96'd0);
    check("ovr_held", 96'(m_axis_tvalid), 96'd1);
    m_axis_tready = 1'b1;
    idle(1);
    check("ovr_taken", 96'(m_axis_tvalid), 96'd0);

    // Abort after 2 of 4 samples, then clean block of adc=10, cos=1
    cfg_data = mk_cfg(4, 1'b1, 0);
    step(500, 3, 7, 1'b1, 1'b1);
    step(500, 3, 7, 1'b1, 1'b1);
    cfg_data = mk_cfg(4, 1'b0, 0);
    step(500, 3, 7, 1'b1, 1'b1);
    cfg_data = mk_cfg(4, 1'b1, 0);
    q_exp.push_back(pk(40, 0));
    for (int k = 0; k < 4; k++) step(10, 1, 0, 1'b1, 1'b1);
    for (int j = 0; j < 4; j++) begin
      idle(1);
      check("abort_tvalid", 96'(m_axis_tvalid), 96'(j == 1));
    end
    cfg_data = mk_cfg(4, 1'b0, 0);
    idle(2);

    // Asynchronous reset mid-stream with a pending, overrun result
    m_axis_tready = 1'b0;
    cfg_data = mk_cfg(2, 1'b1, 0);
    for (int k = 0; k < 6; k++) step(200, 1, 1, 1'b1, 1'b1);
    check("pre_rst_tvalid", 96'(m_axis_tvalid), 96'd1);
    check("pre_rst_overrun", 96'(status_overrun), 96'd1);
    #3;
    aresetn = 1'b0;
    #1;
    check("arst_tvalid", 96'(m_axis_tvalid), 96'd0);
    check("arst_tdata", m_axis_tdata, 96'd0);
    check("arst_overrun", 96'(status_overrun), 96'd0);
    repeat (2) @(posedge clk);
    #2;
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    cfg_data = mk_cfg(4, 1'b1, 0);
    q_exp.push_back(pk(-24, 60));
    for (int k = 0; k < 4; k++) step(3, -2, 5, 1'b1, 1'b1);
    for (int j = 0; j < 4; j++) begin
      idle(1);
      check("post_rst_tvalid", 96'(m_axis_tvalid), 96'(j == 1));
    end

    // Bounded drain of any outstanding results
    for (int i = 0; i < 50 && q_exp.size() > 0; i++) @(posedge clk);
    #1;
    check("sb_empty", 96'(q_exp.size()), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/signal_demodulator.md
# signal_demodulator

Receive-side counterpart of the DAC signal generator. Takes the ADC sample stream and the same DDS reference (cos/sin) that drives the generator, multiplies each sample by the reference and integrates over a configurable block of N samples. It emits one I/Q result pair per block on an AXI-Stream master for readout by the PS/DMA path.

## Interface
- AXIS_TDATA_WIDTH, 16: width of ADC sample and of each reference component.
- ADC_WIDTH, 14: significant ADC bits; samples arrive sign-extended to AXIS_TDATA_WIDTH.
- CFG_DATA_WIDTH, 64: width of cfg_data.
- ACC_WIDTH, 48: accumulator width per channel.
- LEN_WIDTH, 16: width of block length N.

Ports:
- clk  in  1  sample clock, 125 MHz.
- aresetn  in  1  reset, asynchronous, active-low.
- s_axis_adc_tdata  in  AXIS_TDATA_WIDTH  signed ADC sample.
- s_axis_adc_tvalid  in  1  ADC sample valid.
- s_axis_ref_tdata  in  2*AXIS_TDATA_WIDTH  signed reference: [15:0] cos, [31:16] sin.
- s_axis_ref_tvalid  in  1  reference valid.
- cfg_data  in  CFG_DATA_WIDTH  [2:0] ref type (0 sine, 1 square), [3] enable, [31:16] N.
- m_axis_tdata  out  2*ACC_WIDTH  {Q, I}, signed.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream accept.
- status_overrun  out  1  sticky: a result was overwritten before being accepted.

## Operation
- Input streams have no tready; a sample is accepted in every cycle where adc_tvalid && ref_tvalid && enable.
- Pipeline: S1 registers ADC and reference. S2 forms products. S3 accumulates.
- Sine mode: I += adc*cos, Q += adc*sin (signed 16x16 -> 32).
- Square mode: each product is +adc if the reference component is >= 0, otherwise -adc.
- Ref types other than 0/1 behave as sine.
- Accumulators sign-extend products to ACC_WIDTH. There is no saturation; 32+16 bits cannot overflow for N <= 65535.
- States:
  - IDLE: enable = 0. Counter and accumulators are held at 0. Goes to ACCUM when enable = 1.
  - ACCUM: counts samples reaching S3. N is latched at block start; N = 0 is treated as 1.
  - On the Nth sample, the final sums (including that sample) load the output register and m_axis_tvalid is set. The accumulators restart with the next sample, so there are no dead cycles between blocks.
- Output handshake:
  - Result is held until m_axis_tvalid && m_axis_tready.
  - If a new result arrives while tvalid = 1 and tready = 0, it overwrites the held result, tvalid stays 1, and status_overrun is set.
  - If a new result and a handshake occur in the same cycle, the new result loads and there is no overrun.
- Enable deasserted mid-block: the partial block and in-flight pipeline samples are discarded and the state returns to IDLE. A pending output result is kept until it is taken.
- status_overrun clears only in IDLE or on reset.
- cfg changes other than enable take effect at the next block start.

## Timing
- Reset values:
  - m_axis_tvalid = 0, m_axis_tdata = 0, status_overrun = 0.
  - Pipeline, counter and accumulators = 0; state = IDLE.
- Latency: the Nth accepted input at cycle t gives m_axis_tvalid = 1 at t+3.
- Throughput: one sample per clock.
- Reset is asynchronous: outputs go to reset values immediately, regardless of clk.

## Configuration
- DEMOD_SQUARE_REF_EN:
  - Defined: ref type 1 selects square-reference mode (sign multiplication, no multipliers used for that path).
  - Undefined: cfg_data[2:0] is ignored and the block is sine-only.

## Structure
- Package signal_demodulator_pkg holds:
  - cfg bit positions: REF_TYPE_LSB/MSB, ENABLE_BIT, LEN_LSB/MSB.
  - ref-type enum: REF_SINE = 0, REF_SQUARE = 1.
  - state enum: IDLE, ACCUM.
- Sub-module demod_mac: one channel's multiply (or sign-select) plus accumulator with clear/load. Instantiated twice, for I and Q. Counter, FSM and output register sit in the top level.

## Test plan
- Sine mode, ADC = 1000, cos = 16384, sin = 0, N = 4 -> I = 65,536,000, Q = 0; tvalid 3 cycles after the 4th sample; next result 4 cycles later.
- Square mode (macro defined), ADC = 1000, cos = -5, sin = 7, N = 2 -> I = -2000, Q = 2000.
- ref_tvalid toggling every other cycle, N = 4 -> only joint-valid samples counted; result after 4 accepted samples.
- tready = 0 across two blocks -> second result replaces the first, status_overrun = 1; enable low -> status_overrun = 0, pending result still delivered when tready rises.
- Enable dropped after 2 of 4 samples, then re-enabled with ADC = 10, cos = 1 -> I = 40 (no residue from the aborted block).
- aresetn low mid-block, asynchronous to clk -> tvalid, tdata and overrun = 0 immediately; after release the first block starts cleanly.
